alu_op_sequencer: RTL and testbench

Multi-cycle control sequencer for the 32-bit ALU.
- Accepts one operation request (start + opcode).
- Drives the ALU's per-operation select strobes for the required number of cycles.
- Waits for the registered result to settle, then pulses register write enables for the LO/HI result halves.
- Sits between the CPU control unit and the ALU; MUL and DIV get extra cycles, and DIV holds its strobe so its LO quotient sees the updated HI.

---
 rtl/alu_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle strobe and result write-enable sequencer for the 32-bit ALU.
// Optional build macro ALU_SEQ_DIVZERO_EN: DIV accepted with B == 0 completes at once with an error.
module alu_op_sequencer #(
  parameter int SETTLE_CYC = 1,
  parameter int MUL_WAIT   = 2,
  parameter int DIV_HOLD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic        b_is_zero,
  output logic [12:0] op_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        lo_we,
  output logic        hi_we
);

  // state  | meaning
  // IDLE   | waiting for start; only state that samples start/opcode
  // ISSUE  | strobing op_sel[opc]; 1 cycle, DIV_HOLD cycles for DIV
  // WAIT   | strobes off, letting the registered ALU result settle
  // DONE   | one-cycle completion: done, plus write enables or err
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] OP_MUL  = 5'd11;
  localparam logic [4:0] OP_DIV  = 5'd12;
  localparam logic [4:0] OP_LAST = 5'd12;

  // The counter holds "cycles remaining minus one", so terminal count is zero.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] MUL_LD    = 4'(MUL_WAIT - 1);
  localparam logic [3:0] DIV_LD    = 4'(DIV_HOLD - 1);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..15");
  end
  if (MUL_WAIT < 1 || MUL_WAIT > 15) begin : g_bad_mul
    $error("MUL_WAIT must be in 1..15");
  end
  if (DIV_HOLD < 1 || DIV_HOLD > 15) begin : g_bad_div
    $error("DIV_HOLD must be in 1..15");
  end

  logic [1:0] state_q, state_d;
  logic [4:0] opc_q, opc_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic       div_by_zero;

`ifdef ALU_SEQ_DIVZERO_EN
  assign div_by_zero = (opcode == OP_DIV) && b_is_zero;
`else
  logic unused_b_is_zero;
  assign div_by_zero      = 1'b0;
  assign unused_b_is_zero = b_is_zero;
`endif

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opc_d = opcode;
          err_d = 1'b0;
          if (opcode > OP_LAST || div_by_zero) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            cnt_d   = (opcode == OP_DIV) ? DIV_LD : 4'd0;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_WAIT;
          cnt_d   = (opc_q == OP_MUL) ? MUL_LD : SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opc_q   <= 5'd0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode only registered state, so start never reaches them combinationally.
  always_comb begin
    op_sel = 13'd0;
    if (state_q == ST_ISSUE) begin
      op_sel = 13'd1 << opc_q;
    end
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    err   = done && err_q;
    lo_we = done && !err_q;
    hi_we = done && !err_q && ((opc_q == OP_MUL) || (opc_q == OP_DIV));
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus with a queue scoreboard and an independent output monitor.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic        b_is_zero = 1'b0;
  logic [12:0] op_sel;
  logic        busy, done, err, lo_we, hi_we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel_cnt = 0;

  typedef struct {
    int          acc;
    int          ilen;
    int          done_cyc;
    logic [12:0] sel;
    logic        err;
    logic        hi;
  } exp_t;

  exp_t sb[$];

  alu_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .b_is_zero (b_is_zero),
    .op_sel    (op_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lo_we     (lo_we),
    .hi_we     (hi_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      sel_cnt = 0;
    end else begin
      chk("op_sel_onehot", int'($countones(op_sel) <= 1), 1);
      if (!done && (err || lo_we || hi_we))
        chk("pulse_without_done", {29'd0, err, lo_we, hi_we}, 0);
      if (op_sel != 13'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_op_sel", int'(op_sel), 0);
        end else begin
          chk("op_sel_value", int'(op_sel), int'(sb[0].sel));
          chk("op_sel_window", int'(cyc >= sb[0].acc && cyc < sb[0].acc + sb[0].ilen), 1);
          sel_cnt++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc - e.acc, e.done_cyc - e.acc);
          chk("err", int'(err), int'(e.err));
          chk("lo_we", int'(lo_we), int'(!e.err));
          chk("hi_we", int'(hi_we), int'(e.hi));
          chk("busy_at_done", int'(busy), 1);
          chk("strobe_cycles", sel_cnt, e.ilen);
        end
        sel_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 60);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Issue one request in the next IDLE cycle, push its expectation, then scramble inputs.
  task automatic issue(input logic [4:0] op, input logic bz, input int ilen, input int wlen,
                       input logic e_err, input logic e_hi, input logic [12:0] sel);
    exp_t e;
    wait_idle();
    start     = 1'b1;
    opcode    = op;
    b_is_zero = bz;
    e.acc      = cyc + 1;
    e.ilen     = ilen;
    e.done_cyc = e.acc + ilen + wlen;
    e.sel      = sel;
    e.err      = e_err;
    e.hi       = e_hi;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    opcode    = 5'd3;
    b_is_zero = ~bz;
  endtask

  initial begin
    int acc0;
    int n;
    #2;
    chk("rst_op_sel", int'(op_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_lo_we", int'(lo_we), 0);
    chk("rst_hi_we", int'(hi_we), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(5'd0,  1'b0, 1, 1, 1'b0, 1'b0, 13'h0001);   // ADD
    issue(5'd11, 1'b0, 1, 2, 1'b0, 1'b1, 13'h0800);   // MUL
    issue(5'd12, 1'b0, 2, 1, 1'b0, 1'b1, 13'h1000);   // DIV
    issue(5'd7,  1'b1, 1, 1, 1'b0, 1'b0, 13'h0080);   // SHRA
    issue(5'd20, 1'b0, 0, 0, 1'b1, 1'b0, 13'h0000);   // illegal
    issue(5'd0,  1'b0, 1, 1, 1'b0, 1'b0, 13'h0001);   // ADD right after the error
    issue(5'd13, 1'b0, 0, 0, 1'b1, 1'b0, 13'h0000);   // first illegal code
    issue(5'd10, 1'b0, 1, 1, 1'b0, 1'b0, 13'h0400);   // ROL
`ifdef ALU_SEQ_DIVZERO_EN
    issue(5'd12, 1'b1, 0, 0, 1'b1, 1'b0, 13'h0000);
`else
    issue(5'd12, 1'b1, 2, 1, 1'b0, 1'b1, 13'h1000);
`endif

    // start held high with ROR: accepted only from IDLE, one op per 4 cycles
    wait_idle();
    start  = 1'b1;
    opcode = 5'd9;
    acc0   = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.acc      = acc0 + 4 * i;
      e.ilen     = 1;
      e.done_cyc = e.acc + 2;
      e.sel      = 13'h0200;
      e.err      = 1'b0;
      e.hi       = 1'b0;
      sb.push_back(e);
    end
    n = 0;
    while (cyc < acc0 + 8 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;

    // reset asserted while in ISSUE aborts with no completion
    wait_idle();
    start  = 1'b1;
    opcode = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("pre_reset_issue", int'(op_sel), 32'h0200);
    reset = 1'b1;
    #1;
    chk("abort_op_sel", int'(op_sel), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_we", int'(lo_we | hi_we), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort_busy", int'(busy), 0);

    issue(5'd8, 1'b0, 1, 1, 1'b0, 1'b0, 13'h0100);   // SHL after abort

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
